// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, signed/unsigned per request, fixed 33-cycle result latency
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_dividend_tvalid,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tuser,
  output logic               s_axis_dividend_tready,
  input  logic               s_axis_divisor_tvalid,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               s_axis_divisor_tready,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH:0] shl, trial;
  logic [WIDTH-1:0] qfix, rfix;
  logic go, a_neg, b_neg;
  assign go = state_q == IDLE && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
  assign a_neg = s_axis_dividend_tuser & s_axis_dividend_tdata[WIDTH-1];
  assign b_neg = s_axis_dividend_tuser & s_axis_divisor_tdata[WIDTH-1];
  assign shl = {rem_q, quo_q[WIDTH-1]};
  assign trial = shl - {1'b0, dvs_q};
  assign qfix = dvs_q == '0 ? '1 : qneg_q ? -quo_q : quo_q;
  assign rfix = dvs_q == '0 ? dvd_q : rneg_q ? -rem_q : rem_q;
  assign s_axis_dividend_tready = state_q == IDLE;
  assign s_axis_divisor_tready = state_q == IDLE;
  assign m_axis_dout_tvalid = state_q == DONE;
  assign m_axis_dout_tdata = dout_q;
  always_comb begin
    state_d = go ? CALC
            : state_q == CALC ? (cnt_q == CW'(WIDTH - 1) ? FIX : CALC)
            : state_q == FIX ? DONE
            : state_q == DONE ? IDLE : state_q;
    cnt_d = state_q == CALC ? cnt_q + 1'b1 : '0;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    dvd_d = dvd_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dout_d = dout_q;
    if (go) begin
      rem_d = '0;
      quo_d = a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
      dvs_d = b_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
      dvd_d = s_axis_dividend_tdata;
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
    end else if (state_q == CALC) begin
      rem_d = trial[WIDTH] ? shl[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end else if (state_q == FIX) begin
      dout_d = {qfix, rfix};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      dvd_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      dvd_q <= dvd_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dout_q <= dout_d;
    end
  end
endmodule
